// File: rtl/pc_gen.sv
// Fetch program-counter generator: owns the fetch PC, drives IFU flush on redirects,
// and tracks the PC of the instruction held in the IFU IR. Optional feature: RVC_EN.
module pc_gen #(
    parameter int unsigned          PC_SIZE   = 32,
    parameter logic [PC_SIZE-1:0]   RESET_VEC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_pcg_i_jump_req,
    input  logic [PC_SIZE-1:0] exu_pcg_i_jump_pc,
    input  logic               excp_pcg_i_trap_req,
    input  logic [PC_SIZE-1:0] excp_pcg_i_trap_pc,
    input  logic               ifu_pcg_i_valid,
    input  logic               exu_pcg_i_ready,
    input  logic               ifu_pcg_i_len16,
    output logic [PC_SIZE-1:0] pcg_ifu_o_pc_nxt,
    output logic               pcg_ifu_o_flush_req,
    output logic [PC_SIZE-1:0] pcg_exu_o_pc,
    output logic               pcg_o_misalign,
    output logic [PC_SIZE-1:0] pcg_o_badaddr
);

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [PC_SIZE-1:0] INC_32 = PC_SIZE'(4);
    localparam logic [PC_SIZE-1:0] INC_16 = PC_SIZE'(2);

    state_e             state_q, state_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic [PC_SIZE-1:0] exu_pc_q, exu_pc_d;
    logic               flush_q, flush_d;
    logic               misalign_q, misalign_d;
    logic [PC_SIZE-1:0] badaddr_q, badaddr_d;
    logic               pend_q, pend_d;
    logic [PC_SIZE-1:0] pend_pc_q, pend_pc_d;

    logic               fire;
    logic [PC_SIZE-1:0] inc;
    logic [PC_SIZE-1:0] pc_inc;
    logic [PC_SIZE-1:0] trap_tgt;
    logic               jump_bad;

    assign fire     = ifu_pcg_i_valid & exu_pcg_i_ready;
    assign trap_tgt = {excp_pcg_i_trap_pc[PC_SIZE-1:2], 2'b00};

`ifdef RVC_EN
    assign inc      = ifu_pcg_i_len16 ? INC_16 : INC_32;
    assign jump_bad = exu_pcg_i_jump_pc[0];
    logic [1:0] unused_trap_lsb;
    assign unused_trap_lsb = excp_pcg_i_trap_pc[1:0];
`else
    assign inc      = INC_32;
    assign jump_bad = |exu_pcg_i_jump_pc[1:0];
    logic [2:0] unused_in;
    assign unused_in = {ifu_pcg_i_len16, excp_pcg_i_trap_pc[1:0]};
`endif

    assign pc_inc = pc_q + inc;

    // Next-state: fire advances pc; redirects (trap > pending trap > jump) override it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        exu_pc_d   = exu_pc_q;
        misalign_d = 1'b0;
        badaddr_d  = badaddr_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;

        unique case (state_q)
            ST_FLUSH: begin
                if (fire) begin
                    exu_pc_d = pc_q;
                    pc_d     = pc_inc;
                    state_d  = ST_RUN;
                end
                // Traps during a flush wait until the target has been handed over.
                if (excp_pcg_i_trap_req) begin
                    pend_d    = 1'b1;
                    pend_pc_d = trap_tgt;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    exu_pc_d = pc_q;
                    pc_d     = pc_inc;
                end
                if (excp_pcg_i_trap_req) begin
                    pc_d    = trap_tgt;
                    state_d = ST_FLUSH;
                    pend_d  = 1'b0;
                end else if (pend_q) begin
                    pc_d    = pend_pc_q;
                    state_d = ST_FLUSH;
                    pend_d  = 1'b0;
                end else if (exu_pcg_i_jump_req) begin
                    if (jump_bad) begin
                        misalign_d = 1'b1;
                        badaddr_d  = exu_pcg_i_jump_pc;
                    end else begin
                        pc_d    = exu_pcg_i_jump_pc;
                        state_d = ST_FLUSH;
                    end
                end
            end
            default: state_d = ST_FLUSH;
        endcase

        flush_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FLUSH;
            pc_q       <= RESET_VEC;
            exu_pc_q   <= '0;
            flush_q    <= 1'b1;
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            exu_pc_q   <= exu_pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            badaddr_q  <= badaddr_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign pcg_ifu_o_pc_nxt    = pc_q;
    assign pcg_ifu_o_flush_req = flush_q;
    assign pcg_exu_o_pc        = exu_pc_q;
    assign pcg_o_misalign      = misalign_q;
    assign pcg_o_badaddr       = badaddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen; each vector is one clock of inputs and
// the expected registered outputs after that edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_req;
    logic [31:0] jump_pc;
    logic        trap_req;
    logic [31:0] trap_pc;
    logic        valid;
    logic        ready;
    logic        len16;
    logic [31:0] pc_nxt;
    logic        flush_req;
    logic [31:0] exu_pc;
    logic        misalign;
    logic [31:0] badaddr;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef RVC_EN
    localparam logic [31:0] BAD_TGT = 32'h203;
    localparam logic [31:0] INC16   = 32'd2;
`else
    localparam logic [31:0] BAD_TGT = 32'h202;
    localparam logic [31:0] INC16   = 32'd4;
`endif

    pc_gen dut (
        .clk                 (clk),
        .rst                 (rst),
        .exu_pcg_i_jump_req  (jump_req),
        .exu_pcg_i_jump_pc   (jump_pc),
        .excp_pcg_i_trap_req (trap_req),
        .excp_pcg_i_trap_pc  (trap_pc),
        .ifu_pcg_i_valid     (valid),
        .exu_pcg_i_ready     (ready),
        .ifu_pcg_i_len16     (len16),
        .pcg_ifu_o_pc_nxt    (pc_nxt),
        .pcg_ifu_o_flush_req (flush_req),
        .pcg_exu_o_pc        (exu_pc),
        .pcg_o_misalign      (misalign),
        .pcg_o_badaddr       (badaddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        jreq;
        logic [31:0] jpc;
        logic        treq;
        logic [31:0] tpc;
        logic        fire;
        logic [31:0] e_pc;
        logic        e_flush;
        logic [31:0] e_exu;
        logic        e_mis;
        logic [31:0] e_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic jq, logic [31:0] jp, logic tq, logic [31:0] tp,
                                logic f, logic [31:0] p, logic fl, logic [31:0] e,
                                logic m, logic [31:0] b);
        vec_t v;
        v.rst = r; v.jreq = jq; v.jpc = jp; v.treq = tq; v.tpc = tp; v.fire = f;
        v.e_pc = p; v.e_flush = fl; v.e_exu = e; v.e_mis = m; v.e_bad = b;
        return v;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic check_all(int idx, logic [31:0] p, logic fl, logic [31:0] e,
                             logic m, logic [31:0] b);
        check("pc_nxt",    idx, pc_nxt,            p);
        check("flush_req", idx, {31'b0, flush_req}, {31'b0, fl});
        check("exu_pc",    idx, exu_pc,            e);
        check("misalign",  idx, {31'b0, misalign},  {31'b0, m});
        check("badaddr",   idx, badaddr,           b);
    endtask

    task automatic step(logic r, logic jq, logic [31:0] jp, logic tq, logic [31:0] tp,
                        logic v, logic rd, logic l16);
        rst = r; jump_req = jq; jump_pc = jp; trap_req = tq; trap_pc = tp;
        valid = v; ready = rd; len16 = l16;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; jump_req = 1'b0; jump_pc = '0; trap_req = 1'b0; trap_pc = '0;
        valid = 1'b0; ready = 1'b0; len16 = 1'b0;

        //            rst jq jpc           tq tpc      f  pc            fl exu           m  bad
        vecs.push_back(mk(1, 0, 0,            0, 0,     0, 32'h0,        1, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h4,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h8,        0, 32'h4,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     0, 32'h8,        0, 32'h4,        0, 0));
        vecs.push_back(mk(0, 1, 32'h3c,       0, 0,     0, 32'h3c,       1, 32'h4,        0, 0));
        vecs.push_back(mk(0, 1, 32'h500,      0, 0,     0, 32'h3c,       1, 32'h4,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h40,       0, 32'h3c,       0, 0));
        vecs.push_back(mk(0, 1, 32'h200,      0, 0,     1, 32'h200,      1, 32'h40,       0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     0, 32'h200,      1, 32'h40,       0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h204,      0, 32'h200,      0, 0));
        vecs.push_back(mk(0, 1, 32'h300,      1, 32'h83, 0, 32'h80,      1, 32'h200,      0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h84,       0, 32'h80,       0, 0));
        vecs.push_back(mk(0, 1, BAD_TGT,      0, 0,     1, 32'h88,       0, 32'h84,       1, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     0, 32'h88,       0, 32'h84,       0, BAD_TGT));
        vecs.push_back(mk(0, 1, 32'h200,      0, 0,     0, 32'h200,      1, 32'h84,       0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            1, 32'h80, 0, 32'h200,     1, 32'h84,       0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h204,      0, 32'h200,      0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     0, 32'h80,       1, 32'h200,      0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h84,       0, 32'h80,       0, BAD_TGT));
        vecs.push_back(mk(0, 1, 32'h400,      0, 0,     0, 32'h400,      1, 32'h80,       0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            1, 32'h80, 0, 32'h400,     1, 32'h80,       0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            1, 32'h90, 0, 32'h400,     1, 32'h80,       0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h404,      0, 32'h400,      0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            0, 0,     0, 32'h90,       1, 32'h400,      0, BAD_TGT));
        vecs.push_back(mk(0, 0, 0,            1, 32'h10, 0, 32'h90,      1, 32'h400,      0, BAD_TGT));
        vecs.push_back(mk(1, 0, 0,            0, 0,     0, 32'h0,        1, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h4,        0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h8,        0, 32'h4,        0, 0));
        vecs.push_back(mk(0, 1, 32'hffff_fffc, 0, 0,    0, 32'hffff_fffc, 1, 32'h4,       0, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0,     1, 32'h0,        0, 32'hffff_fffc, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].jreq, vecs[i].jpc, vecs[i].treq, vecs[i].tpc,
                 vecs[i].fire, vecs[i].fire, 1'b0);
            check_all(i, vecs[i].e_pc, vecs[i].e_flush, vecs[i].e_exu,
                      vecs[i].e_mis, vecs[i].e_bad);
        end

        // Valid without ready must not advance.
        step(0, 0, 0, 0, 0, 1, 0, 0);
        check_all(100, 32'h0, 1'b0, 32'hffff_fffc, 1'b0, 32'h0);

        // Mixed instruction lengths from 0x100.
        step(0, 1, 32'h100, 0, 0, 0, 0, 0);
        check_all(200, 32'h100, 1'b1, 32'hffff_fffc, 1'b0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        check_all(201, 32'h100 + INC16, 1'b0, 32'h100, 1'b0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        check_all(202, 32'h104 + INC16, 1'b0, 32'h100 + INC16, 1'b0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        check_all(203, 32'h104 + 2 * INC16, 1'b0, 32'h104 + INC16, 1'b0, 32'h0);

        // Halfword-aligned target: legal only with compressed support.
        step(0, 1, 32'h202, 0, 0, 0, 0, 0);
`ifdef RVC_EN
        check_all(300, 32'h202, 1'b1, 32'h104 + INC16, 1'b0, 32'h0);
`else
        check_all(300, 32'h104 + 2 * INC16, 1'b0, 32'h104 + INC16, 1'b1, 32'h202);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
